// File: rtl/var_state_wr.sv
// var_state_wr: write side of the variable state list (decision writes, backtrack clearing).
// Define PARALLEL_BKT_EN to clear all qualifying variables in one SCAN cycle instead of serially.
module var_state_wr #(
  parameter int NUM   = 8,
  parameter int WIDTH = 3,
  parameter int LVL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dcd_valid_i,
  input  logic [NUM-1:0]         dcd_index_i,
  input  logic [WIDTH-1:0]       dcd_value_i,
  input  logic [LVL_W-1:0]       dcd_level_i,
  output logic                   dcd_ready_o,
  input  logic                   bkt_valid_i,
  input  logic [LVL_W-1:0]       bkt_level_i,
  output logic                   bkt_ready_o,
  output logic                   bkt_done_o,
  output logic [NUM*WIDTH-1:0]   value_o,
  output logic [NUM*LVL_W-1:0]   level_o,
  output logic                   busy_o,
  output logic                   err_o
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, next;
  logic [LVL_W-1:0] blvl;
  logic [NUM-1:0] sel, clr;
  logic scan_last, wr_req, wr_ok, tgt_used, bkt_acc;
`ifdef PARALLEL_BKT_EN
  assign scan_last = 1'b1;
  assign sel = '1;
`else
  localparam int PW = NUM > 1 ? $clog2(NUM) : 1;
  logic [PW-1:0] ptr;
  assign scan_last = ptr == PW'(NUM - 1);
  always_comb
    for (int i = 0; i < NUM; i++) sel[i] = ptr == PW'(i);
  // Saturating pointer: stops at NUM-1 so non-power-of-two NUM never indexes past the list.
  always_ff @(posedge clk)
    if (!rst_n || bkt_acc) ptr <= '0;
    else if (state == SCAN && !scan_last) ptr <= ptr + PW'(1);
`endif
  assign bkt_acc = state == IDLE && bkt_valid_i;
  assign wr_req  = state == IDLE && dcd_valid_i && !bkt_valid_i;
  assign wr_ok   = dcd_index_i != '0 && (dcd_index_i & (dcd_index_i - NUM'(1))) == '0
                   && !tgt_used && dcd_value_i != '0;
  always_comb begin
    tgt_used = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      tgt_used = tgt_used | (dcd_index_i[i] && value_o[i*WIDTH +: WIDTH] != '0);
      clr[i] = sel[i] && value_o[i*WIDTH +: WIDTH] != '0 && level_o[i*LVL_W +: LVL_W] >= blvl;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (bkt_valid_i ? SCAN : IDLE) :
           state == SCAN ? (scan_last ? DONE : SCAN) : IDLE;
  always_comb begin
    dcd_ready_o = state == IDLE;
    bkt_ready_o = state == IDLE;
    busy_o      = state != IDLE;
    bkt_done_o  = state == DONE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      value_o <= '0;
      level_o <= '0;
      err_o   <= 1'b0;
      blvl    <= '0;
    end else begin
      err_o <= wr_req && !wr_ok;
      if (bkt_acc) blvl <= bkt_level_i;
      for (int i = 0; i < NUM; i++)
        if (wr_req && wr_ok && dcd_index_i[i]) begin
          value_o[i*WIDTH +: WIDTH] <= dcd_value_i;
          level_o[i*LVL_W +: LVL_W] <= dcd_level_i;
        end else if (state == SCAN && clr[i]) begin
          value_o[i*WIDTH +: WIDTH] <= '0;
          level_o[i*LVL_W +: LVL_W] <= '0;
        end
    end
endmodule

// File: tb/tb_var_state_wr.sv
// tb_var_state_wr: random + directed bench for var_state_wr at NUM=8 and NUM=5 against an array model.
module tb_var_state_wr;
`ifdef PARALLEL_BKT_EN
  localparam int EA = 2, EB = 2;
`else
  localparam int EA = 9, EB = 6;
`endif
  logic clk = 1'b0, rst_n = 1'b0, dv = 1'b0, bv = 1'b0;
  logic [7:0] idx = '0;
  logic [2:0] dval = '0;
  logic [3:0] dlvl = '0, blvl = '0;
  logic rdy_da, rdy_ba, done_a, busy_a, err_a;
  logic rdy_db, rdy_bb, done_b, busy_b, err_b;
  logic [23:0] value_a;
  logic [31:0] level_a;
  logic [14:0] value_b;
  logic [19:0] level_b;
  int checks = 0, failures = 0;
  int mv[2][8], ml[2][8];
  int nv[2] = '{8, 5};

  always #5 clk = ~clk;

  var_state_wr #(.NUM(8), .WIDTH(3), .LVL_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .dcd_valid_i(dv), .dcd_index_i(idx), .dcd_value_i(dval),
    .dcd_level_i(dlvl), .dcd_ready_o(rdy_da), .bkt_valid_i(bv), .bkt_level_i(blvl),
    .bkt_ready_o(rdy_ba), .bkt_done_o(done_a), .value_o(value_a), .level_o(level_a),
    .busy_o(busy_a), .err_o(err_a));

  var_state_wr #(.NUM(5), .WIDTH(3), .LVL_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .dcd_valid_i(dv), .dcd_index_i(idx[4:0]), .dcd_value_i(dval),
    .dcd_level_i(dlvl), .dcd_ready_o(rdy_db), .bkt_valid_i(bv), .bkt_level_i(blvl),
    .bkt_ready_o(rdy_bb), .bkt_done_o(done_b), .value_o(value_b), .level_o(level_b),
    .busy_o(busy_b), .err_o(err_b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) begin
        mv[d][i] = 0;
        ml[d][i] = 0;
      end
  endtask

  task automatic cmp_all(input string tag);
    logic [23:0] ea;
    logic [31:0] la;
    logic [14:0] eb;
    logic [19:0] lb;
    ea = '0; la = '0; eb = '0; lb = '0;
    for (int i = 0; i < 8; i++) begin
      ea[i*3 +: 3] = 3'(mv[0][i]);
      la[i*4 +: 4] = 4'(ml[0][i]);
    end
    for (int i = 0; i < 5; i++) begin
      eb[i*3 +: 3] = 3'(mv[1][i]);
      lb[i*4 +: 4] = 4'(ml[1][i]);
    end
    chk({tag, "/val8"}, value_a, ea);
    chk({tag, "/lvl8"}, level_a, la);
    chk({tag, "/val5"}, value_b, eb);
    chk({tag, "/lvl5"}, level_b, lb);
  endtask

  task automatic idle_zero(input string tag);
    chk({tag, "/zero8"}, {value_a, level_a}, '0);
    chk({tag, "/zero5"}, {value_b, level_b}, '0);
    chk({tag, "/flags8"}, {rdy_da, rdy_ba, done_a, busy_a, err_a}, 5'b11000);
    chk({tag, "/flags5"}, {rdy_db, rdy_bb, done_b, busy_b, err_b}, 5'b11000);
  endtask

  task automatic do_write(input logic [7:0] i_idx, input logic [2:0] v, input logic [3:0] l);
    bit ok[2];
    @(negedge clk);
    dv = 1'b1; idx = i_idx; dval = v; dlvl = l;
    @(posedge clk); #1;
    dv = 1'b0;
    for (int d = 0; d < 2; d++) begin
      int sub, pos;
      sub = int'(i_idx) & ((1 << nv[d]) - 1);
      pos = 0;
      for (int i = 0; i < nv[d]; i++) if (sub == (1 << i)) pos = i;
      ok[d] = $countones(sub) == 1 && v != 0 && mv[d][pos] == 0;
      if (ok[d]) begin
        mv[d][pos] = int'(v);
        ml[d][pos] = int'(l);
      end
    end
    chk("err8", err_a, !ok[0]);
    chk("err5", err_b, !ok[1]);
    cmp_all("write");
    @(posedge clk); #1;
    chk("err8_drop", err_a, 1'b0);
    chk("err5_drop", err_b, 1'b0);
  endtask

  task automatic do_bkt(input logic [3:0] l, input bit with_d, input bit hold);
    @(negedge clk);
    bv = 1'b1; blvl = l;
    if (with_d) begin
      dv = 1'b1; idx = 8'h08; dval = 3'd5; dlvl = 4'd7;
    end
    @(posedge clk); #1;
    bv = 1'b0;
    if (!hold) dv = 1'b0;
    for (int k = 1; k <= EA; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      chk($sformatf("done8_k%0d", k), done_a, k == EA);
      chk($sformatf("done5_k%0d", k), done_b, k == EB);
      chk("rdy8_low", {rdy_da, rdy_ba, busy_a}, 3'b001);
      chk("bkt_err", {err_a, err_b}, 2'b00);
      if (k == EB) dv = 1'b0;
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < nv[d]; i++)
        if (mv[d][i] != 0 && ml[d][i] >= int'(l)) begin
          mv[d][i] = 0;
          ml[d][i] = 0;
        end
    cmp_all("bkt");
    @(posedge clk); #1;
    chk("bkt_idle", {rdy_da, rdy_db, busy_a, busy_b, done_a, done_b}, 6'b110000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_write(8'b0000_0100, 3'b001, 4'd2);
    chk("wr_slice_val", value_a[8:6], 3'b001);
    chk("wr_slice_lvl", level_a[11:8], 4'd2);
    do_write(8'b0000_0110, 3'b010, 4'd1);
    do_write(8'b0000_0100, 3'b010, 4'd5);
    do_write(8'b0000_1000, 3'b000, 4'd1);

    do_reset();
    do_write(8'h01, 3'd1, 4'd1);
    do_write(8'h02, 3'd2, 4'd2);
    do_write(8'h04, 3'd3, 4'd3);
    do_bkt(4'd2, 1'b0, 1'b0);
    chk("bkt_keep_val0", value_a[2:0], 3'd1);
    chk("bkt_keep_lvl0", level_a[3:0], 4'd1);
    chk("bkt_clr_var12", {value_a[8:3], level_a[11:4]}, '0);

    do_write(8'h10, 3'd6, 4'd9);
    do_bkt(4'd0, 1'b1, 1'b0);
    do_write(8'h02, 3'd4, 4'd3);
    do_bkt(4'd15, 1'b1, 1'b1);

    do_write(8'h01, 3'd7, 4'd4);
    do_write(8'h80, 3'd2, 4'd6);
    @(negedge clk);
    bv = 1'b1; blvl = 4'd0;
    @(posedge clk); #1;
    bv = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    clear_model();
    idle_zero("midscan_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_nodone", {done_a, done_b, busy_a, busy_b}, 4'b0000);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        do_bkt(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      else
        do_write($urandom_range(0, 4) == 0 ? 8'($urandom) : 8'(1 << $urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
